// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART transmitter (and the future
// receiver).
//   * PARITY_NONE / PARITY_EVEN / PARITY_ODD : parity mode encodings
//   * uart_state_t plus ST_* constants       : transmitter FSM states
//   * cycles_per_bit(clk_mhz, baud)          : clocks per bit, truncated
//   * parity_bit(d, mode)                    : parity for up to 8 data bits
package uart_pkg;

   localparam logic [1:0] PARITY_NONE = 2'd0;
   localparam logic [1:0] PARITY_EVEN = 2'd1;
   localparam logic [1:0] PARITY_ODD  = 2'd2;

   typedef logic [2:0] uart_state_t;

   localparam uart_state_t ST_IDLE   = 3'd0;
   localparam uart_state_t ST_START  = 3'd1;
   localparam uart_state_t ST_DATA   = 3'd2;
   localparam uart_state_t ST_PARITY = 3'd3;
   localparam uart_state_t ST_STOP   = 3'd4;
   localparam uart_state_t ST_BREAK  = 3'd5;

   // Computed in 64 bits so large clock frequencies cannot overflow.
   function automatic int unsigned cycles_per_bit(input int unsigned clk_mhz,
                                                  input int unsigned baud);
      longint unsigned hz;
      hz = 64'(clk_mhz) * 64'd1000000;
      if (baud == 32'd0) begin
         return 32'd0;
      end else begin
         return 32'(hz / 64'(baud));
      end
   endfunction

   // Data narrower than 8 bits is zero-extended by the caller; the extra
   // zeros do not change the XOR.
   function automatic logic parity_bit(input logic [7:0] d, input logic [1:0] mode);
      case (mode)
         PARITY_EVEN: return ^d;
         PARITY_ODD:  return ~^d;
         default:     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo -- synchronous first-word-fall-through FIFO for the UART
// transmitter.
//   clk, rst : clock and synchronous active-high reset (empties the FIFO)
//   push/din : write din when push && !full
//   pop/dout : dout shows the oldest entry; pop && !empty removes it
//   full, empty, level : occupancy status from the registered level
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   LVL_ZERO = (AW+1)'(0);
   localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      level_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   // Qualify requests against the registered occupancy.
   always_comb begin
      push_ok_s = push && (level_r != LVL_FULL);
      pop_ok_s  = pop  && (level_r != LVL_ZERO);
   end

   // Pointers and level; a simultaneous push and pop leaves the level unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         level_r  <= LVL_ZERO;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   level_r <= level_r + LVL_ONE;
            2'b01:   level_r <= level_r - LVL_ONE;
            default: level_r <= level_r;
         endcase
      end
   end

   // Storage array; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   assign dout  = mem_r[rd_ptr_r];
   assign full  = (level_r == LVL_FULL);
   assign empty = (level_r == LVL_ZERO);
   assign level = level_r;

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg -- configurable UART transmitter with a small transmit FIFO.
//   clk, rst   : clock and synchronous active-high reset
//   data/valid : byte to queue; accepted on an edge where valid && ready
//   ready      : FIFO has room
//   tx         : serial line, idle high, registered
//   busy       : a frame (or break/guard time) is in progress, registered
//   fifo_level : number of queued entries
//   brk        : line-break request (only with UART_TX_BREAK_EN defined)
// Optional feature macro: UART_TX_BREAK_EN adds the brk input. After the
// current frame, the line is held low while brk=1. When brk falls, the line
// is held idle-high for one stop period before the next start bit.
module uart_tx_cfg import uart_pkg::*; #(
   parameter int CLK_FREQ   = 27,
   parameter int BAUD       = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DATA_BITS-1:0]          data,
   input  logic                          valid,
   output logic                          ready,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef UART_TX_BREAK_EN
   ,
   input  logic                          brk
`endif
);

   localparam int unsigned CYCLE   = cycles_per_bit(CLK_FREQ, BAUD);
   localparam int          LW      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [31:0] BIT_LAST  = 32'(CYCLE - 1);
   localparam logic [2:0]  DATA_LAST = 3'(DATA_BITS - 1);
   localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);
   localparam logic [1:0]  PAR_MODE  = 2'(PARITY);

   localparam bit CFG_OK = (CYCLE >= 2) && (DATA_BITS >= 5) && (DATA_BITS <= 8) &&
                           (PARITY >= 0) && (PARITY <= 2) &&
                           (STOP_BITS >= 1) && (STOP_BITS <= 2) &&
                           (FIFO_DEPTH >= 2) && ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0);

   if (!CFG_OK) begin : g_bad_cfg
      $error("uart_tx_cfg: illegal parameter set (CYCLE, DATA_BITS, PARITY, STOP_BITS or FIFO_DEPTH)");
   end

   uart_state_t          state_r;
   logic [31:0]          cnt_r;
   logic [2:0]           idx_r;
   logic [DATA_BITS-1:0] shift_r;
   logic                 par_r;
   logic                 tx_r;
   logic                 busy_r;

   logic [DATA_BITS-1:0] fifo_dout_s;
   logic                 fifo_full_s;
   logic                 fifo_empty_s;
   logic [LW-1:0]        fifo_level_s;
   logic                 push_s;
   logic                 pop_s;
   logic                 brk_s;
   logic                 bit_end_s;
   logic                 stop_end_s;

   uart_tx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s),
      .pop   (pop_s),
      .din   (data),
      .dout  (fifo_dout_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .level (fifo_level_s)
   );

   // Break request, tied off when the feature is not built.
   always_comb begin
`ifdef UART_TX_BREAK_EN
      brk_s = brk;
`else
      brk_s = 1'b0;
`endif
   end

   // Bit-boundary decode and FIFO handshake. A pending break takes priority
   // over starting the next frame, so the queued entry stays in the FIFO.
   always_comb begin
      bit_end_s  = (cnt_r == BIT_LAST);
      stop_end_s = bit_end_s && (idx_r == STOP_LAST);
      push_s     = valid && !fifo_full_s;
      pop_s      = 1'b0;
      case (state_r)
         ST_IDLE: pop_s = !fifo_empty_s && !brk_s;
         ST_STOP: pop_s = stop_end_s && !fifo_empty_s && !brk_s;
         default: pop_s = 1'b0;
      endcase
   end

   // Shift latch: loaded on pop, shifted at each start/data bit boundary so
   // bit 0 always holds the next data bit to drive.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_r <= '0;
         par_r   <= 1'b0;
      end else if (pop_s) begin
         shift_r <= fifo_dout_s;
         par_r   <= parity_bit(8'(fifo_dout_s), PAR_MODE);
      end else if (bit_end_s && ((state_r == ST_START) || (state_r == ST_DATA))) begin
         shift_r <= {1'b0, shift_r[DATA_BITS-1:1]};
      end
   end

   // Frame FSM, baud counter and the tx/busy output registers. idx_r counts
   // data bits in DATA and stop bits in STOP.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         cnt_r   <= 32'd0;
         idx_r   <= 3'd0;
         tx_r    <= 1'b1;
         busy_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               cnt_r <= 32'd0;
               idx_r <= 3'd0;
               if (brk_s) begin
                  state_r <= ST_BREAK;
                  tx_r    <= 1'b0;
                  busy_r  <= 1'b1;
               end else if (!fifo_empty_s) begin
                  state_r <= ST_START;
                  tx_r    <= 1'b0;
                  busy_r  <= 1'b1;
               end else begin
                  tx_r    <= 1'b1;
                  busy_r  <= 1'b0;
               end
            end
            ST_START: begin
               if (bit_end_s) begin
                  state_r <= ST_DATA;
                  cnt_r   <= 32'd0;
                  idx_r   <= 3'd0;
                  tx_r    <= shift_r[0];
               end else begin
                  cnt_r   <= cnt_r + 32'd1;
               end
            end
            ST_DATA: begin
               if (bit_end_s) begin
                  cnt_r <= 32'd0;
                  if (idx_r == DATA_LAST) begin
                     idx_r <= 3'd0;
                     if (PAR_MODE != PARITY_NONE) begin
                        state_r <= ST_PARITY;
                        tx_r    <= par_r;
                     end else begin
                        state_r <= ST_STOP;
                        tx_r    <= 1'b1;
                     end
                  end else begin
                     idx_r <= idx_r + 3'd1;
                     tx_r  <= shift_r[0];
                  end
               end else begin
                  cnt_r <= cnt_r + 32'd1;
               end
            end
            ST_PARITY: begin
               if (bit_end_s) begin
                  state_r <= ST_STOP;
                  cnt_r   <= 32'd0;
                  idx_r   <= 3'd0;
                  tx_r    <= 1'b1;
               end else begin
                  cnt_r   <= cnt_r + 32'd1;
               end
            end
            ST_STOP: begin
               if (stop_end_s) begin
                  cnt_r <= 32'd0;
                  idx_r <= 3'd0;
                  if (brk_s) begin
                     state_r <= ST_BREAK;
                     tx_r    <= 1'b0;
                  end else if (!fifo_empty_s) begin
                     state_r <= ST_START;
                     tx_r    <= 1'b0;
                  end else begin
                     state_r <= ST_IDLE;
                     tx_r    <= 1'b1;
                     busy_r  <= 1'b0;
                  end
               end else if (bit_end_s) begin
                  cnt_r <= 32'd0;
                  idx_r <= idx_r + 3'd1;
               end else begin
                  cnt_r <= cnt_r + 32'd1;
               end
            end
            ST_BREAK: begin
               // On release, reuse STOP as the idle-high guard period.
               cnt_r <= 32'd0;
               idx_r <= 3'd0;
               if (!brk_s) begin
                  state_r <= ST_STOP;
                  tx_r    <= 1'b1;
               end else begin
                  tx_r    <= 1'b0;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               cnt_r   <= 32'd0;
               idx_r   <= 3'd0;
               tx_r    <= 1'b1;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign ready      = !fifo_full_s;
   assign fifo_level = fifo_level_s;
   assign tx         = tx_r;
   assign busy       = busy_r;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg -- scoreboard bench for uart_tx_cfg (CYCLE = 10).
//   u0: 8N1, u1: 7 data bits + even parity + 2 stop bits, u2: 8 data bits + odd parity + 1 stop bit.
// Expected frames are queued per instance when a byte is pushed. A monitor
// per instance captures each frame from tx and compares it against the head
// of its queue.
module tb_uart_tx_cfg;

   typedef struct {
      logic [7:0] data;
      logic       par;
      int         gap;   // required idle samples before this frame, -1 = any
   } exp_t;

   logic       clk;
   logic       rst_w   [3];
   logic [7:0] data_w  [3];
   logic       valid_w [3];
   logic       ready_w [3];
   logic       tx_w    [3];
   logic       busy_w  [3];
   logic [2:0] lvl_w   [3];
   bit         mon_en  [3];
`ifdef UART_TX_BREAK_EN
   logic       brk0;
`endif

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];
   int   checks = 0;
   int   errors = 0;

   uart_tx_cfg #(.CLK_FREQ(1), .BAUD(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
      .clk(clk), .rst(rst_w[0]), .data(data_w[0]), .valid(valid_w[0]), .ready(ready_w[0]),
      .tx(tx_w[0]), .busy(busy_w[0]), .fifo_level(lvl_w[0])
`ifdef UART_TX_BREAK_EN
      , .brk(brk0)
`endif
   );

   uart_tx_cfg #(.CLK_FREQ(1), .BAUD(100000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
      .clk(clk), .rst(rst_w[1]), .data(data_w[1][6:0]), .valid(valid_w[1]), .ready(ready_w[1]),
      .tx(tx_w[1]), .busy(busy_w[1]), .fifo_level(lvl_w[1])
`ifdef UART_TX_BREAK_EN
      , .brk(1'b0)
`endif
   );

   uart_tx_cfg #(.CLK_FREQ(1), .BAUD(100000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
      .clk(clk), .rst(rst_w[2]), .data(data_w[2]), .valid(valid_w[2]), .ready(ready_w[2]),
      .tx(tx_w[2]), .busy(busy_w[2]), .fifo_level(lvl_w[2])
`ifdef UART_TX_BREAK_EN
      , .brk(1'b0)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit exceeded");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic int q_size(input int k);
      case (k)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   function automatic exp_t pop_exp(input int k);
      case (k)
         0:       return q0.pop_front();
         1:       return q1.pop_front();
         default: return q2.pop_front();
      endcase
   endfunction

   // Valid is held from a negedge through the first posedge at which ready is high.
   task automatic push(input int k, input logic [7:0] d);
      int n = 0;
      @(negedge clk);
      data_w[k]  = d;
      valid_w[k] = 1'b1;
      while (ready_w[k] !== 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) begin
         chk("push_timeout", 32'(n), 32'd0);
      end
      @(posedge clk);
      #1 valid_w[k] = 1'b0;
   endtask

   task automatic drain(input int k);
      int n = 0;
      while ((q_size(k) != 0 || busy_w[k] !== 1'b0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) begin
         chk("drain_timeout", 32'(n), 32'd0);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic monitor(input int k, input int nbits, input int haspar, input int nstop);
      int         flen;
      int         gap;
      int         slot;
      bit         abort;
      exp_t       e;
      logic [199:0] gv, ev, bv, bm;
      flen = (1 + nbits + haspar + nstop) * 10;
      gap  = -1;
      forever begin
         @(negedge clk);
         if (!mon_en[k] || rst_w[k] !== 1'b0) begin
            gap = -1;
         end else if (tx_w[k] === 1'b0) begin
            gv = '0; bv = '0; ev = '0; bm = '0; abort = 1'b0;
            bv[0] = busy_w[k];
            for (int i = 1; i < flen; i++) begin
               @(negedge clk);
               gv[i] = tx_w[k];
               bv[i] = busy_w[k];
               if (rst_w[k] !== 1'b0) abort = 1'b1;
            end
            if (!abort) begin
               checks++;
               if (q_size(k) == 0) begin
                  errors++;
                  $display("FAIL frame_unexpected dut%0d: got frame %h, expected no frame", k, gv);
               end else begin
                  e = pop_exp(k);
                  for (int i = 0; i < flen; i++) begin
                     slot = i / 10;
                     bm[i] = 1'b1;
                     if (slot == 0)                              ev[i] = 1'b0;
                     else if (slot <= nbits)                     ev[i] = e.data[slot-1];
                     else if (haspar != 0 && slot == nbits + 1)  ev[i] = e.par;
                     else                                        ev[i] = 1'b1;
                  end
                  if (gv !== ev) begin
                     errors++;
                     $display("FAIL frame_bits dut%0d byte %h: got %h, expected %h", k, e.data, gv, ev);
                  end
                  checks++;
                  if (bv !== bm) begin
                     errors++;
                     $display("FAIL frame_busy dut%0d byte %h: got %h, expected %h", k, e.data, bv, bm);
                  end
                  if (e.gap >= 0) chk("frame_gap", 32'(gap), 32'(e.gap));
               end
               gap = 0;
            end else begin
               gap = -1;
            end
         end else if (tx_w[k] === 1'b1 && gap >= 0) begin
            gap++;
         end
      end
   endtask

   initial begin
      fork
         monitor(0, 8, 0, 1);
         monitor(1, 7, 1, 2);
         monitor(2, 8, 1, 1);
      join_none
   end

   initial begin
      int n;
      int lows;
      for (int k = 0; k < 3; k++) begin
         rst_w[k] = 1'b1; valid_w[k] = 1'b0; data_w[k] = 8'h00; mon_en[k] = 1'b1;
      end
`ifdef UART_TX_BREAK_EN
      brk0 = 1'b0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_tx",    32'(tx_w[0]),   32'd1);
      chk("rst_busy",  32'(busy_w[0]), 32'd0);
      chk("rst_ready", 32'(ready_w[0]), 32'd1);
      chk("rst_level", 32'(lvl_w[0]),  32'd0);
      chk("rst_tx_u1", 32'(tx_w[1]),   32'd1);
      chk("rst_tx_u2", 32'(tx_w[2]),   32'd1);
      for (int k = 0; k < 3; k++) rst_w[k] = 1'b0;
      repeat (2) @(negedge clk);

      // Test 1: 8N1, 0xA5, latency and busy length.
      q0.push_back('{data: 8'hA5, par: 1'b0, gap: -1});
      push(0, 8'hA5);
      @(negedge clk);
      chk("t1_tx_idle_after_push", 32'(tx_w[0]), 32'd1);
      chk("t1_busy_after_push",    32'(busy_w[0]), 32'd0);
      @(negedge clk);
      chk("t1_latency_tx",   32'(tx_w[0]), 32'd0);
      chk("t1_latency_busy", 32'(busy_w[0]), 32'd1);
      n = 1;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (busy_w[0] === 1'b1) n++;
         else break;
      end
      chk("t1_busy_len", 32'(n), 32'd100);
      drain(0);

      // Test 2: 7 data bits, even parity, 2 stop bits.
      q1.push_back('{data: 8'h53, par: 1'b0, gap: -1});
      push(1, 8'h53);
      drain(1);

      // Test 3: odd parity on 0x00 and 0x01, back to back.
      q2.push_back('{data: 8'h00, par: 1'b1, gap: -1});
      q2.push_back('{data: 8'h01, par: 1'b0, gap: 0});
      push(2, 8'h00);
      push(2, 8'h01);
      drain(2);

      // Test 4: six bytes, FIFO full/ready behaviour, contiguous frames.
      q0.push_back('{data: 8'h11, par: 1'b0, gap: -1});
      q0.push_back('{data: 8'h22, par: 1'b0, gap: 0});
      q0.push_back('{data: 8'h33, par: 1'b0, gap: 0});
      q0.push_back('{data: 8'h44, par: 1'b0, gap: 0});
      q0.push_back('{data: 8'h55, par: 1'b0, gap: 0});
      q0.push_back('{data: 8'h66, par: 1'b0, gap: 0});
      push(0, 8'h11);
      push(0, 8'h22);
      push(0, 8'h33);
      push(0, 8'h44);
      push(0, 8'h55);
      @(negedge clk);
      chk("t4_level_full", 32'(lvl_w[0]),  32'd4);
      chk("t4_ready_low",  32'(ready_w[0]), 32'd0);
      push(0, 8'h66);
      @(negedge clk);
      chk("t4_level_refill", 32'(lvl_w[0]),  32'd4);
      chk("t4_ready_refill", 32'(ready_w[0]), 32'd0);
      n = 0;
      while (ready_w[0] !== 1'b1 && n < 150) begin
         @(negedge clk);
         n++;
      end
      chk("t4_ready_reassert", 32'(ready_w[0]), 32'd1);
      chk("t4_level_after_pop", 32'(lvl_w[0]), 32'd3);
      drain(0);

      // Test 5: reset during the third data bit, two bytes still queued.
      push(0, 8'h3C);
      push(0, 8'h5A);
      push(0, 8'h7E);
      repeat (34) @(negedge clk);
      rst_w[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("t5_rst_tx",    32'(tx_w[0]),    32'd1);
      chk("t5_rst_busy",  32'(busy_w[0]),  32'd0);
      chk("t5_rst_ready", 32'(ready_w[0]), 32'd1);
      chk("t5_rst_level", 32'(lvl_w[0]),   32'd0);
      #1 rst_w[0] = 1'b0;
      lows = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (tx_w[0] !== 1'b1) lows++;
      end
      chk("t5_no_frames", 32'(lows), 32'd0);

`ifdef UART_TX_BREAK_EN
      // Test 6: break raised mid-frame, queued byte follows after the guard.
      begin
         logic sv [200];
         int   bcnt;
         mon_en[0] = 1'b0;
         push(0, 8'hC3);
         push(0, 8'h3C);
         bcnt = 0;
         for (int i = 0; i < 180; i++) begin
            @(negedge clk);
            sv[i] = tx_w[0];
            if (busy_w[0] === 1'b1) bcnt++;
            if (i == 40)  brk0 = 1'b1;
            if (i == 149) brk0 = 1'b0;
         end
         chk("t6_start_bit", 32'(sv[5]),  32'd0);
         chk("t6_data_bit0", 32'(sv[15]), 32'd1);
         chk("t6_data_bit2", 32'(sv[35]), 32'd0);
         chk("t6_stop_bit",  32'(sv[95]), 32'd1);
         lows = 0;
         for (int i = 100; i < 150; i++) if (sv[i] === 1'b0) lows++;
         chk("t6_break_low", 32'(lows), 32'd50);
         n = 0;
         for (int i = 150; i < 160; i++) if (sv[i] === 1'b1) n++;
         chk("t6_guard_high", 32'(n), 32'd10);
         chk("t6_next_start", 32'(sv[160]), 32'd0);
         chk("t6_busy_all",   32'(bcnt), 32'd180);
         drain(0);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
